uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Derived constants: BIT_TICKS = CLOCK_FREQ/BAUD (integer division); HALF_TICKS = BIT_TICKS/2.
REQ-004 Port clk  input  1  sole system clock; all state updates on rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port rx  input  1  asynchronous serial line; idle high; frame is start(0), 8 data bits LSB first, stop(1).
REQ-007 Port rx_data  output  8  last received byte; valid while rx_valid=1.
REQ-008 Port rx_valid  output  1  byte available; held until consumed.
REQ-009 Port rx_ready  input  1  consumer accepts the byte when rx_valid=1 and rx_ready=1 on the same edge.
REQ-010 Port frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 Port overrun  output  1  one-cycle pulse when a good byte completes while rx_valid is still 1.
REQ-012 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 rx passes through a 2-flop synchronizer to give rx_s; the FSM uses only rx_s and its 1-cycle-delayed copy.
REQ-014 The FSM has states IDLE, START, DATA, STOP and BREAK.
REQ-015 IDLE->START on a falling edge of rx_s (previous 1, current 0); the tick counter clears on the same edge.
REQ-016 START: counter runs to HALF_TICKS-1; at that point rx_s=0 -> DATA (counter cleared, bit index 0); rx_s=1 -> IDLE (glitch rejected, no output activity).
REQ-017 DATA: counter runs to BIT_TICKS-1, then samples rx_s into the shift register at bit position = bit index (LSB first) and clears the counter; after the 8th sample -> STOP.
REQ-018 STOP: after BIT_TICKS-1 counts, samples rx_s; 1 -> byte good, return to IDLE; 0 -> frame_err pulse and go to BREAK.
REQ-019 BREAK: stays until rx_s=1, then IDLE; no new start is detected while in BREAK.
REQ-020 Good byte with rx_valid=0, or with rx_valid=1 and rx_ready=1 on that edge: on the next edge rx_data = new byte, rx_valid = 1.
REQ-021 Good byte with rx_valid=1 and rx_ready=0: new byte dropped, rx_data unchanged, overrun=1 for one cycle.
REQ-022 rx_valid clears on the edge after rx_valid=1 and rx_ready=1, unless REQ-020 sets it again on that edge.
REQ-023 A frame_err byte never updates rx_data or rx_valid.
REQ-024 The counter is wide enough for BIT_TICKS-1 (at least 16 bits); the bit index is 3 bits and never wraps within a frame.
REQ-025 Sample points relative to the falling-edge detect cycle T: start at T+HALF_TICKS, data bit k at T+HALF_TICKS+(k+1)*BIT_TICKS, stop at T+HALF_TICKS+9*BIT_TICKS (±1 cycle).
REQ-026 rx_ready is ignored while rx_valid=0.

Reset
REQ-027 While rst_n=0: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, counter=0, bit index=0, synchronizer flops=1.
REQ-028 Reset asserted mid-frame aborts the frame immediately; after release the block waits for a fresh falling edge.

Verification
REQ-029 Bench uses CLOCK_FREQ=1600000 and BAUD=100000 (BIT_TICKS=16, HALF_TICKS=8) unless stated otherwise.
REQ-030 Send 0x55 with rx_ready=1. Required: rx_valid pulses for 1 cycle with rx_data=0x55; frame_err=0; overrun=0; busy drops after the stop sample.
REQ-031 Send 0xA3 then 0x0F back-to-back with rx_ready=0. Required: rx_data=0xA3 and rx_valid=1 held; overrun pulses once at the end of the 0x0F frame; rx_data stays 0xA3. Then assert rx_ready for 1 cycle. Required: rx_valid=0.
REQ-032 Drive rx low for 4 cycles, then high. Required: FSM returns to IDLE at the half-bit sample; no rx_valid, frame_err or overrun activity.
REQ-033 Send 0x81 with the stop bit forced to 0, then hold rx low for 40 cycles, then release. Required: frame_err pulses once; rx_valid stays 0; busy stays 1 until rx returns high; a following 0x7E is received correctly.
REQ-034 Assert rst_n=0 during data bit 4 of a frame, then release. Required: all outputs return to reset values; the frame tail produces no output; the next full frame 0xC6 is received correctly.
REQ-035 Loop back the existing uart_tx (same parameters, default CLOCK_FREQ and BAUD) into rx and send "Hello\n". Required: six rx_valid events with data 0x48, 0x65, 0x6C, 0x6C, 0x6F, 0x0A, and no errors.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with ready/valid byte handoff.
//
// Parameters
//   CLOCK_FREQ  system clock frequency in Hz
//   BAUD        serial bit rate
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial input, idle high
//   rx_data    last received byte, valid while rx_valid is high
//   rx_valid   byte available, held until accepted
//   rx_ready   consumer accepts the byte when rx_valid and rx_ready are both high
//   frame_err  one-cycle pulse on a bad stop bit
//   overrun    one-cycle pulse when a good byte arrives while rx_valid is still high
//   busy       receiver is not idle
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to mid start bit; line high there means a glitch
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; low means framing error
// BREAK | line held low after a framing error; wait for it to go high

module uart_rx #(
    parameter int CLOCK_FREQ = 100000000,
    parameter int BAUD       = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int BIT_TICKS  = CLOCK_FREQ / BAUD;
    localparam int HALF_TICKS = BIT_TICKS / 2;
    localparam int CNT_W      = ($clog2(BIT_TICKS) > 16) ? $clog2(BIT_TICKS) : 16;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [7:0]       data_nxt;
    logic             valid_nxt;
    logic             frame_err_nxt;
    logic             overrun_nxt;
    logic             byte_good;

    // rx_meta/rx_s form the synchronizer; rx_d is the delayed copy used for
    // edge detection. All reset high so a line idling high after reset does
    // not look like a start bit.
    logic rx_meta, rx_s, rx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift     <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift     <= shift_nxt;
            rx_data   <= data_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        data_nxt      = rx_data;
        valid_nxt     = rx_valid;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;
        byte_good     = 1'b0;

        if (rx_valid && rx_ready) begin
            valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (rx_d && !rx_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rx_s;
                    // bit_idx parks at 7 rather than wrapping; it is
                    // re-cleared on the next start.
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        byte_good = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = BREAK;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A byte accepted on the same edge frees the holding register, so the
        // new byte can replace it without an overrun.
        if (byte_good) begin
            if (!rx_valid || rx_ready) begin
                data_nxt  = shift;
                valid_nxt = 1'b1;
            end else begin
                overrun_nxt = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
